// File: rtl/pipe_exe_if.sv
// pipe_exe_if -- signal bundle between the D/E register, the forwarding
// network and the execute stage.
//   master : drives the D/E register fields and forwarding data, sees results
//   slave  : the execute stage (pipe_exe)
// Inputs to EXE : ea, eb, eimm, epc4, ealuc, ealuimm, ejal, ewreg, em2reg,
//                 ewmem, ern, ea_depen, eb_depen, m_alu, m_mo, w_data
// Outputs of EXE: e_alu, e_b, e_rn, e_wreg, e_m2reg, e_wmem, e_busy
interface pipe_exe_if;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] eimm;
  logic [31:0] epc4;
  logic [4:0]  ealuc;
  logic        ealuimm;
  logic        ejal;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [4:0]  ern;
  logic [1:0]  ea_depen;
  logic [1:0]  eb_depen;
  logic [31:0] m_alu;
  logic [31:0] m_mo;
  logic [31:0] w_data;
  logic [31:0] e_alu;
  logic [31:0] e_b;
  logic [4:0]  e_rn;
  logic        e_wreg;
  logic        e_m2reg;
  logic        e_wmem;
  logic        e_busy;

  modport master (
    output ea, eb, eimm, epc4, ealuc, ealuimm, ejal, ewreg, em2reg, ewmem,
           ern, ea_depen, eb_depen, m_alu, m_mo, w_data,
    input  e_alu, e_b, e_rn, e_wreg, e_m2reg, e_wmem, e_busy
  );

  modport slave (
    input  ea, eb, eimm, epc4, ealuc, ealuimm, ejal, ewreg, em2reg, ewmem,
           ern, ea_depen, eb_depen, m_alu, m_mo, w_data,
    output e_alu, e_b, e_rn, e_wreg, e_m2reg, e_wmem, e_busy
  );
endinterface

// File: rtl/pipe_exe.sv
// pipe_exe -- execute stage of the 5-stage pipeline.
// Forwards operands, runs the single-cycle ALU, and owns the hi/lo registers
// with an iterative (32-step radix-2) multiply/divide unit.
// Ports:
//   clk  : clock, all state on posedge
//   clrn : asynchronous active-low reset
//   bus  : pipe_exe_if.slave (D/E fields, forwarding data, E-stage results,
//          e_busy stall request)
module pipe_exe (
  input  logic       clk,
  input  logic       clrn,
  pipe_exe_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_LUI  = 5'b00101;
  localparam logic [4:0] OP_SLL  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b01000;
  localparam logic [4:0] OP_SLT  = 5'b01001;
  localparam logic [4:0] OP_SLTU = 5'b01010;
  localparam logic [4:0] OP_NOR  = 5'b01011;
  localparam logic [4:0] OP_MFHI = 5'b10100;
  localparam logic [4:0] OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_MTHI = 5'b10110;
  localparam logic [4:0] OP_MTLO = 5'b10111;

  // md_op_r encoding follows ealuc[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  logic [1:0]  state_r;
  logic [4:0]  count_r;
  logic [1:0]  md_op_r;
  logic [31:0] a_r;        // raw captured fa (signs, div-by-zero result)
  logic [31:0] b_r;        // raw captured fb
  logic [31:0] mag_a_r;    // multiplicand magnitude
  logic [31:0] mag_b_r;    // divisor magnitude
  logic [63:0] work_r;     // mult: {partial, multiplier}; div: {rem, quotient}
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic [31:0] fa_s;
  logic [31:0] fb_s;
  logic [31:0] alu_b_s;
  logic [31:0] alu_s;
  logic        md_req_s;
  logic        md_signed_s;
  logic [31:0] mag_fa_s;
  logic [31:0] mag_fb_s;
  logic [32:0] md_sum_s;
  logic [32:0] md_shift_s;
  logic [32:0] md_diff_s;
  logic [63:0] work_nxt_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;
  logic        last_step_s;

  // Two's-complement magnitude; unsigned operands pass straight through.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    logic [31:0] m;
    if (is_signed && v[31]) begin
      m = (~v) + 32'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

  assign md_req_s    = (bus.ealuc[4:2] == 3'b100);
  assign md_signed_s = ~bus.ealuc[0];
  assign mag_fa_s    = magnitude(fa_s, md_signed_s);
  assign mag_fb_s    = magnitude(fb_s, md_signed_s);
  assign last_step_s = (state_r == BUSY) && (count_r == 5'd31);

  // Operand A forwarding select.
  always_comb begin
    case (bus.ea_depen)
      2'b00:   fa_s = bus.ea;
      2'b01:   fa_s = bus.m_alu;
      2'b10:   fa_s = bus.w_data;
      2'b11:   fa_s = bus.m_mo;
      default: fa_s = bus.ea;
    endcase
  end

  // Operand B forwarding select.
  always_comb begin
    case (bus.eb_depen)
      2'b00:   fb_s = bus.eb;
      2'b01:   fb_s = bus.m_alu;
      2'b10:   fb_s = bus.w_data;
      2'b11:   fb_s = bus.m_mo;
      default: fb_s = bus.eb;
    endcase
  end

  assign alu_b_s = bus.ealuimm ? bus.eimm : fb_s;

  // Single-cycle ALU; shift amount always comes from fa, shifted value from B.
  always_comb begin
    alu_s = 32'd0;
    case (bus.ealuc)
      OP_ADD:  alu_s = fa_s + alu_b_s;
      OP_SUB:  alu_s = fa_s - alu_b_s;
      OP_AND:  alu_s = fa_s & alu_b_s;
      OP_OR:   alu_s = fa_s | alu_b_s;
      OP_XOR:  alu_s = fa_s ^ alu_b_s;
      OP_LUI:  alu_s = alu_b_s << 5'd16;
      OP_SLL:  alu_s = alu_b_s << fa_s[4:0];
      OP_SRL:  alu_s = alu_b_s >> fa_s[4:0];
      OP_SRA:  alu_s = $unsigned($signed(alu_b_s) >>> fa_s[4:0]);
      OP_SLT:  alu_s = {31'd0, ($signed(fa_s) < $signed(alu_b_s))};
      OP_SLTU: alu_s = {31'd0, (fa_s < alu_b_s)};
      OP_NOR:  alu_s = ~(fa_s | alu_b_s);
      OP_MFHI: alu_s = hi_r;
      OP_MFLO: alu_s = lo_r;
      default: alu_s = 32'd0;
    endcase
  end

  // One radix-2 step: shift-add for multiply, restoring step for divide.
  always_comb begin
    md_sum_s   = 33'd0;
    md_shift_s = 33'd0;
    md_diff_s  = 33'd0;
    work_nxt_s = work_r;
    if (md_op_r[1] == 1'b0) begin
      md_sum_s   = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, mag_a_r} : 33'd0);
      work_nxt_s = {md_sum_s, work_r[31:1]};
    end else begin
      md_shift_s = {work_r[63:32], work_r[31]};
      md_diff_s  = md_shift_s - {1'b0, mag_b_r};
      // No borrow out means the divisor fits: keep the difference, quotient bit 1.
      if (md_diff_s[32] == 1'b0) begin
        work_nxt_s = {md_diff_s[31:0], work_r[30:0], 1'b1};
      end else begin
        work_nxt_s = {md_shift_s[31:0], work_r[30:0], 1'b0};
      end
    end
  end

  // Sign fix-up of the final step into hi/lo values.
  always_comb begin
    res_hi_s = work_nxt_s[63:32];
    res_lo_s = work_nxt_s[31:0];
    case (md_op_r)
      2'b00: begin
        if (a_r[31] ^ b_r[31]) begin
          {res_hi_s, res_lo_s} = (~work_nxt_s) + 64'd1;
        end else begin
          {res_hi_s, res_lo_s} = work_nxt_s;
        end
      end
      2'b01: begin
        {res_hi_s, res_lo_s} = work_nxt_s;
      end
      2'b10, 2'b11: begin
        if (b_r == 32'd0) begin
          // Divide by zero: all-ones quotient, dividend left as remainder.
          res_hi_s = a_r;
          res_lo_s = 32'hFFFF_FFFF;
        end else begin
          if ((md_op_r == 2'b10) && (a_r[31] ^ b_r[31])) begin
            res_lo_s = (~work_nxt_s[31:0]) + 32'd1;
          end else begin
            res_lo_s = work_nxt_s[31:0];
          end
          if ((md_op_r == 2'b10) && a_r[31]) begin
            res_hi_s = (~work_nxt_s[63:32]) + 32'd1;
          end else begin
            res_hi_s = work_nxt_s[63:32];
          end
        end
      end
      default: begin
        res_hi_s = work_nxt_s[63:32];
        res_lo_s = work_nxt_s[31:0];
      end
    endcase
  end

  // Multiply/divide sequencer: capture operands, iterate 32 steps, one DONE cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= IDLE;
      count_r <= 5'd0;
      md_op_r <= 2'b00;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      mag_a_r <= 32'd0;
      mag_b_r <= 32'd0;
      work_r  <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (md_req_s) begin
            md_op_r <= bus.ealuc[1:0];
            a_r     <= fa_s;
            b_r     <= fb_s;
            mag_a_r <= mag_fa_s;
            mag_b_r <= mag_fb_s;
            // Multiplier (mult) or dividend (div) starts in the low half.
            work_r  <= {32'd0, (bus.ealuc[1] ? mag_fa_s : mag_fb_s)};
            count_r <= 5'd0;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          work_r  <= work_nxt_s;
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        // The issuing op is still in E here; leaving unconditionally stops a restart.
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // hi/lo: multiply/divide results on the last step, MTHI/MTLO otherwise.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (last_step_s) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else if ((state_r == IDLE) && (bus.ealuc == OP_MTHI)) begin
      hi_r <= fa_s;
    end else if ((state_r == IDLE) && (bus.ealuc == OP_MTLO)) begin
      lo_r <= fa_s;
    end
  end

  // Stall request is held off while reset is asserted.
  assign bus.e_busy  = clrn & (((state_r == IDLE) & md_req_s) | (state_r == BUSY));
  assign bus.e_alu   = bus.ejal ? (bus.epc4 + 32'd4) : alu_s;
  assign bus.e_b     = fb_s;
  assign bus.e_rn    = bus.ern;
  assign bus.e_m2reg = bus.em2reg;
  assign bus.e_wreg  = bus.ewreg & ~bus.e_busy;
  assign bus.e_wmem  = bus.ewmem & ~bus.e_busy;

endmodule

// File: tb/tb_pipe_exe.sv
// tb_pipe_exe -- self-checking bench for pipe_exe.
// A transaction-level reference model (plain arithmetic for ALU ops and
// 64-bit integer arithmetic for multiply/divide, plus a stall-cycle budget)
// is compared against the DUT on every negative clock edge. Directed steps
// pin the model with literal results; a randomized phase follows.
module tb_pipe_exe;
  bit   clk;
  logic clrn;

  pipe_exe_if bus();

  pipe_exe dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [63:0] m_pend = 64'd0;
  int          m_left = 0;
  bit          m_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] own,
                                      input logic [31:0] malu, input logic [31:0] wdat,
                                      input logic [31:0] mmo);
    case (sel)
      2'd1:    return malu;
      2'd2:    return wdat;
      2'd3:    return mmo;
      default: return own;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
    logic signed [31:0] sb;
    sb = b;
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return {b[15:0], 16'd0};
      5'd6:    return b << a[4:0];
      5'd7:    return b >> a[4:0];
      5'd8:    return sb >>> a[4:0];
      5'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd10:   return (a < b) ? 32'd1 : 32'd0;
      5'd11:   return ~(a | b);
      5'd20:   return hi;
      5'd21:   return lo;
      default: return 32'd0;
    endcase
  endfunction

  // {hi, lo} produced by a multiply/divide op
  function automatic logic [63:0] md_ref(input logic [1:0] k, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (k)
      2'd0: return 64'(sa * sb);
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // compare every cycle, then advance the model to the next edge
  always @(negedge clk) begin
    logic [31:0] fa, fb, bo, exp_alu;
    logic        exp_busy, md;
    fa = fwd(bus.ea_depen, bus.ea, bus.m_alu, bus.w_data, bus.m_mo);
    fb = fwd(bus.eb_depen, bus.eb, bus.m_alu, bus.w_data, bus.m_mo);
    bo = bus.ealuimm ? bus.eimm : fb;
    md = (bus.ealuc >= 5'd16) && (bus.ealuc <= 5'd19);
    exp_busy = (clrn === 1'b1) && ((m_left > 0) || (!m_done && md));
    exp_alu  = bus.ejal ? (bus.epc4 + 32'd4) : alu_ref(bus.ealuc, fa, bo, m_hi, m_lo);
    chk("e_busy",  {31'd0, bus.e_busy},  {31'd0, exp_busy});
    chk("e_alu",   bus.e_alu, exp_alu);
    chk("e_b",     bus.e_b, fb);
    chk("e_rn",    {27'd0, bus.e_rn}, {27'd0, bus.ern});
    chk("e_wreg",  {31'd0, bus.e_wreg},  {31'd0, bus.ewreg & ~exp_busy});
    chk("e_wmem",  {31'd0, bus.e_wmem},  {31'd0, bus.ewmem & ~exp_busy});
    chk("e_m2reg", {31'd0, bus.e_m2reg}, {31'd0, bus.em2reg});
    if (clrn !== 1'b1) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        {m_hi, m_lo} = m_pend;
        m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (md) begin
      m_pend = md_ref(bus.ealuc[1:0], fa, fb);
      m_left = 32;
    end else if (bus.ealuc == 5'd22) begin
      m_hi = fa;
    end else if (bus.ealuc == 5'd23) begin
      m_lo = fa;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    bus.ealuc = c; bus.ea = a; bus.eb = b;
    bus.ea_depen = 2'b00; bus.eb_depen = 2'b00;
    bus.ealuimm = 1'b0; bus.ejal = 1'b0;
    bus.ewreg = 1'b1; bus.em2reg = 1'b0; bus.ewmem = 1'b0; bus.ern = 5'd3;
  endtask

  task automatic pin(input string name, input logic [31:0] exp);
    #2;
    chk(name, bus.e_alu, exp);
  endtask

  // issue a mult/div and count stall cycles (bounded)
  task automatic md_run(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output int nwreg);
    nbusy = 0;
    nwreg = 0;
    op(c, a, b);
    #2;
    for (int k = 0; k < 40; k++) begin
      if (bus.e_busy !== 1'b1) break;
      nbusy++;
      if (bus.e_wreg !== 1'b0) nwreg++;
      @(posedge clk);
      #3;
    end
  endtask

  function automatic logic [31:0] rv32();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_fields();
    bus.ea = rv32(); bus.eb = rv32(); bus.eimm = rv32(); bus.epc4 = $urandom;
    bus.m_alu = rv32(); bus.m_mo = rv32(); bus.w_data = rv32();
    bus.ea_depen = 2'($urandom_range(0, 3));
    bus.eb_depen = 2'($urandom_range(0, 3));
    bus.ealuimm = 1'($urandom_range(0, 1));
    bus.ejal    = ($urandom_range(0, 7) == 0);
    bus.ewreg   = 1'($urandom_range(0, 1));
    bus.em2reg  = 1'($urandom_range(0, 1));
    bus.ewmem   = 1'($urandom_range(0, 1));
    bus.ern     = 5'($urandom_range(0, 31));
  endtask

  logic [4:0] alu_codes [0:19] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                   5'd8, 5'd9, 5'd10, 5'd11, 5'd20, 5'd21, 5'd22,
                                   5'd23, 5'd12, 5'd15, 5'd24, 5'd31};

  initial begin
    int nb, nw;
    clrn = 1'b0;
    op(5'd0, 32'd1, 32'd2);
    bus.eimm = 32'd0; bus.epc4 = 32'd0;
    bus.m_alu = 32'd0; bus.m_mo = 32'd0; bus.w_data = 32'd0;
    #3;
    chk("rst_busy", {31'd0, bus.e_busy}, 32'd0);
    chk("rst_comb_add", bus.e_alu, 32'd3);
    step(); step();
    clrn = 1'b1;
    op(5'd20, 32'd0, 32'd0); pin("rst_hi", 32'd0);
    step(); op(5'd21, 32'd0, 32'd0); pin("rst_lo", 32'd0);

    step(); op(5'd0, 32'd0, 32'd7); bus.ea_depen = 2'b01; bus.m_alu = 32'd5;
    pin("fwd_add", 32'd12);
    step(); op(5'd1, 32'd0, 32'd0); bus.ea_depen = 2'b01; bus.eb_depen = 2'b11; bus.m_mo = 32'd3;
    pin("fwd_sub", 32'd2);
    step(); op(5'd8, 32'd4, 32'hF000_0000); pin("sra", 32'hFF00_0000);
    step(); op(5'd9, 32'hFFFF_FFFF, 32'd1); pin("slt", 32'd1);
    step(); op(5'd10, 32'hFFFF_FFFF, 32'd1); pin("sltu", 32'd0);
    step(); op(5'd0, 32'd1, 32'd1); bus.ejal = 1'b1; bus.epc4 = 32'd100; pin("jal", 32'd104);
    step(); op(5'd5, 32'd0, 32'd0); bus.ealuimm = 1'b1; bus.eimm = 32'h0000_1234;
    pin("lui_imm", 32'h1234_0000);

    step(); md_run(5'd16, 32'hFFFF_FFFE, 32'd3, nb, nw);
    chk("mult_stall", 32'(nb), 32'd33);
    chk("mult_wreg", 32'(nw), 32'd0);
    step(); op(5'd20, 32'd0, 32'd0); pin("mult_hi", 32'hFFFF_FFFF);
    step(); op(5'd21, 32'd0, 32'd0); pin("mult_lo", 32'hFFFF_FFFA);

    step(); md_run(5'd18, 32'hFFFF_FFF9, 32'd2, nb, nw);
    chk("div_stall", 32'(nb), 32'd33);
    step(); op(5'd21, 32'd0, 32'd0); pin("div_lo", 32'hFFFF_FFFD);
    step(); op(5'd20, 32'd0, 32'd0); pin("div_hi", 32'hFFFF_FFFF);
    step(); md_run(5'd19, 32'h1234_5678, 32'd0, nb, nw);
    step(); op(5'd21, 32'd0, 32'd0); pin("divu0_lo", 32'hFFFF_FFFF);
    step(); op(5'd20, 32'd0, 32'd0); pin("divu0_hi", 32'h1234_5678);
    step(); md_run(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, nb, nw);
    step(); op(5'd21, 32'd0, 32'd0); pin("divovf_lo", 32'h8000_0000);
    step(); op(5'd20, 32'd0, 32'd0); pin("divovf_hi", 32'd0);

    step(); md_run(5'd17, 32'd2, 32'd3, nb, nw);
    chk("b2b_stall1", 32'(nb), 32'd33);
    step(); md_run(5'd17, 32'd4, 32'd5, nb, nw);
    chk("b2b_stall2", 32'(nb), 32'd33);
    step(); op(5'd21, 32'd0, 32'd0); pin("b2b_lo", 32'd20);
    step(); op(5'd20, 32'd0, 32'd0); pin("b2b_hi", 32'd0);

    step(); op(5'd22, 32'd7, 32'd0);
    step(); op(5'd23, 32'd8, 32'd0);
    step(); op(5'd16, 32'd3, 32'd5);
    for (int k = 0; k < 10; k++) step();
    clrn = 1'b0;
    #2;
    chk("abort_busy", {31'd0, bus.e_busy}, 32'd0);
    step();
    clrn = 1'b1;
    op(5'd20, 32'd0, 32'd0); pin("abort_hi", 32'd0);
    step(); op(5'd21, 32'd0, 32'd0); pin("abort_lo", 32'd0);
    step(); op(5'd23, 32'd9, 32'd0);
    step(); op(5'd21, 32'd0, 32'd0); pin("mtlo_mflo", 32'd9);

    for (int i = 0; i < 250; i++) begin
      step();
      rand_fields();
      if ($urandom_range(0, 9) == 0) begin
        bus.ealuc = 5'd16 + 5'($urandom_range(0, 3));
        for (int j = 0; j < 33; j++) begin
          step();
          rand_fields();
        end
      end else begin
        bus.ealuc = alu_codes[$urandom_range(0, 19)];
      end
    end
    step();
    op(5'd0, 32'd0, 32'd0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
